vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator, successor to the fixed 640x480 sync block.
//  Porch, sync and active lengths come from parameters, as do sync polarity and counter width.
//  Adds a pixel clock-enable, registered outputs, line/frame start strobes and a frame counter.
//  Sits between the pixel clock domain and the pong renderer/colour mux. The renderer consumes
//  oX/oY/oActive. The strobes drive game-logic updates once per frame.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines)
//  HS_POL    0    0 = HS active-low, 1 = active-high
//  VS_POL    0    0 = VS active-low, 1 = active-high
//  CW        10   width of h/v counters and oX/oY; must hold H_TOTAL-1 and V_TOTAL-1
//  FCW       16   frame counter width
// PORTS
//  iclk         in   1    pixel (or faster) clock
//  irst         in   1    synchronous active-high reset
//  ien          in   1    pixel enable; counters and outputs advance only on edges with ien=1
//  oVGA_HS      out  1    horizontal sync, polarity per HS_POL
//  oVGA_VS      out  1    vertical sync, polarity per VS_POL
//  oActive      out  1    1 while the pixel is in the visible area
//  oX           out  CW   visible column 0..H_ACTIVE-1; 0 when oActive=0
//  oY           out  CW   visible row 0..V_ACTIVE-1; 0 when oActive=0
//  oLineStart   out  1    one-iclk pulse for pixel h=0 of every line
//  oFrameStart  out  1    one-iclk pulse for pixel h=0,v=0 of every frame
//  oFrameCnt    out  FCW  completed-frame count, wraps modulo 2^FCW
// BEHAVIOUR
//  H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
//  Counter ordering is active, front porch, sync, back porch.
//  h counter: 0..H_TOTAL-1. On an edge with ien=1, h wraps to 0 at H_TOTAL-1, otherwise h+1.
//  v counter: advances only when h wraps. It wraps to 0 at V_TOTAL-1.
//  ien=0: counters and all outputs hold, except the strobes, which are 0 on any non-enabled edge.
//  All outputs are registered from the pre-increment counters on enabled edges.
//   Outputs therefore lag the counters by one enabled edge (latency 1).
//  Output decodes, all computed from the sampled (h,v):
//   active = h<H_ACTIVE && v<V_ACTIVE. oX=h, oY=v when active, else 0.
//   HS asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//   VS asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
//   Asserted level = POL; deasserted level = ~POL.
//   oLineStart = (h==0). oFrameStart = (h==0 && v==0).
//  Strobe width: the strobes are 1 for exactly the iclk cycle after the enabled edge that sampled
//   the matching h/v. They return to 0 on the next edge, regardless of ien.
//  oFrameCnt increments on the enabled edge that wraps v from V_TOTAL-1 to 0.
//   It wraps from 2^FCW-1 to 0 with no flag.
//  Reset (irst=1 at an edge, overrides ien): h=v=0, oFrameCnt=0, oActive=0, oX=oY=0,
//   strobes=0, oVGA_HS=~HS_POL, oVGA_VS=~VS_POL.
//  Reset mid-frame aborts the current frame. There is no partial-frame count.
//   The first enabled edge after reset samples h=v=0, so oFrameStart pulses one cycle later.
// TESTING
//  1 Defaults, ien=1, release reset: oFrameStart 1 cycle after first edge;
//    oLineStart period 800 clk, HS low 96 clk starting 656 clk after line start.
//  2 Defaults: VS low for exactly 2 lines (1600 clk) starting at line 490; frame period 420000 clk;
//    307200 oActive cycles/frame; max oX=639, max oY=479.
//  3 ien toggling 1,0,1,0: all periods double, strobes remain 1 iclk wide, outputs hold on ien=0 edges.
//  4 HS_POL=1, VS_POL=1: sync waveforms are exact inversions of test 2; reset levels are 0.
//  5 Small params (H 4/1/2/1, V 3/1/1/1, FCW=2): check every (h,v) decode;
//    oFrameCnt sequence 0,1,2,3,0 after 4 frames.
//  6 Assert irst at h=300,v=200: the next cycle shows all reset values;
//    after release, timing restarts at h=v=0 and oFrameCnt=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with registered outputs, strobes and frame count
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int FCW      = 16
) (
  input  logic           iclk,
  input  logic           irst,
  input  logic           ien,
  output logic           oVGA_HS,
  output logic           oVGA_VS,
  output logic           oActive,
  output logic [CW-1:0]  oX,
  output logic [CW-1:0]  oY,
  output logic           oLineStart,
  output logic           oFrameStart,
  output logic [FCW-1:0] oFrameCnt
);
  localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [CW-1:0] h, v;
  logic h_wrap, v_wrap, act, hs_on, vs_on;
  // Decode the current pre-increment position; inclusive upper bounds avoid overflowing CW
  always_comb begin
    h_wrap = h == H_LAST;
    v_wrap = v == V_LAST;
    act    = h <= H_VIS && v <= V_VIS;
    hs_on  = h >= HS_FIRST && h <= HS_LAST;
    vs_on  = v >= VS_FIRST && v <= VS_LAST;
  end
  // Advance counters and register decodes on enabled edges; strobes clear on every other edge
  always_ff @(posedge iclk) begin
    if (irst) begin
      h           <= '0;
      v           <= '0;
      oFrameCnt   <= '0;
      oActive     <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oLineStart  <= 1'b0;
      oFrameStart <= 1'b0;
      oVGA_HS     <= ~HS_POL;
      oVGA_VS     <= ~VS_POL;
    end else begin
      oLineStart  <= 1'b0;
      oFrameStart <= 1'b0;
      if (ien) begin
        h <= h_wrap ? '0 : h + 1'b1;
        if (h_wrap) v <= v_wrap ? '0 : v + 1'b1;
        if (h_wrap && v_wrap) oFrameCnt <= oFrameCnt + 1'b1;
        oActive     <= act;
        oX          <= act ? h : '0;
        oY          <= act ? v : '0;
        oVGA_HS     <= hs_on ? HS_POL : ~HS_POL;
        oVGA_VS     <= vs_on ? VS_POL : ~VS_POL;
        oLineStart  <= h == '0;
        oFrameStart <= h == '0 && v == '0;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default line timing and full small-raster decode
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_d = 1'b1, ien_d = 1'b1, rst_s = 1'b1, ien_s = 1'b0;
  logic d_hs, d_vs, d_act, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [15:0] d_fc;
  logic s_hs, s_vs, s_act, s_ls, s_fs, p_hs, p_vs, p_act, p_ls, p_fs;
  logic [3:0] s_x, s_y, p_x, p_y;
  logic [1:0] s_fc, p_fc;
  int n_chk = 0, n_pass = 0;
  int mh, mv, mfc, ex, ey;
  logic ea, els, efs, ehs, evs;

  vga_timing_gen u_def (
    .iclk(clk), .irst(rst_d), .ien(ien_d), .oVGA_HS(d_hs), .oVGA_VS(d_vs), .oActive(d_act),
    .oX(d_x), .oY(d_y), .oLineStart(d_ls), .oFrameStart(d_fs), .oFrameCnt(d_fc)
  );
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .CW(4), .FCW(2)) u_sm (
    .iclk(clk), .irst(rst_s), .ien(ien_s), .oVGA_HS(s_hs), .oVGA_VS(s_vs), .oActive(s_act),
    .oX(s_x), .oY(s_y), .oLineStart(s_ls), .oFrameStart(s_fs), .oFrameCnt(s_fc)
  );
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FCW(2)) u_pol (
    .iclk(clk), .irst(rst_s), .ien(ien_s), .oVGA_HS(p_hs), .oVGA_VS(p_vs), .oActive(p_act),
    .oX(p_x), .oY(p_y), .oLineStart(p_ls), .oFrameStart(p_fs), .oFrameCnt(p_fc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One small-raster cycle: predict the coming edge, let it happen, compare at the next negedge
  task automatic cyc(input logic r, input logic e);
    rst_s = r;
    ien_s = e;
    if (r) begin
      mh = 0; mv = 0; mfc = 0; ea = 0; ex = 0; ey = 0; els = 0; efs = 0; ehs = 0; evs = 0;
    end else begin
      els = 0;
      efs = 0;
      if (e) begin
        ea  = mh < 4 && mv < 3;
        ex  = ea ? mh : 0;
        ey  = ea ? mv : 0;
        ehs = mh == 5 || mh == 6;
        evs = mv == 4;
        els = mh == 0;
        efs = mh == 0 && mv == 0;
        if (mh == 7) begin
          mh = 0;
          if (mv == 5) begin
            mv = 0;
            mfc = (mfc + 1) % 4;
          end else mv++;
        end else mh++;
      end
    end
    @(negedge clk);
    chk("s_act", s_act, ea);
    chk("s_x", s_x, ex);
    chk("s_y", s_y, ey);
    chk("s_hs", s_hs, !ehs);
    chk("s_vs", s_vs, !evs);
    chk("s_ls", s_ls, els);
    chk("s_fs", s_fs, efs);
    chk("s_fc", s_fc, mfc);
    chk("p_hs", p_hs, ehs);
    chk("p_vs", p_vs, evs);
    chk("p_act", p_act, ea);
    chk("p_fs", p_fs, efs);
  endtask

  initial begin
    int ls1, ls2, hs_start, hs_len, fs_n, max_x, ls_n, dbl;
    logic prev;
    ls1 = 0; ls2 = 0; hs_start = 0; hs_len = 0; fs_n = 0; max_x = 0;
    repeat (2) @(negedge clk);
    chk("def_rst_act", d_act, 0);
    chk("def_rst_hs", d_hs, 1);
    chk("def_rst_vs", d_vs, 1);
    chk("def_rst_fs", d_fs, 0);
    rst_d = 1'b0;
    @(negedge clk);
    chk("def_fs_first", d_fs, 1);
    chk("def_ls_first", d_ls, 1);
    chk("def_act_first", d_act, 1);
    chk("def_x0", d_x, 0);
    chk("def_fc0", d_fc, 0);
    for (int t = 1; t <= 1600; t++) begin
      @(negedge clk);
      if (d_ls && ls1 == 0) ls1 = t;
      else if (d_ls && ls2 == 0) ls2 = t;
      if (t < 800 && !d_hs) begin
        if (hs_len == 0) hs_start = t;
        hs_len++;
      end
      if (d_fs) fs_n++;
      if (int'(d_x) > max_x) max_x = int'(d_x);
      if (t == 639) chk("def_x639", d_x, 639);
      if (t == 640) chk("def_act640", d_act, 0);
      if (t == 801) chk("def_y1", d_y, 1);
    end
    chk("def_ls_period", ls1, 800);
    chk("def_ls_period2", ls2, 1600);
    chk("def_hs_start", hs_start, 656);
    chk("def_hs_width", hs_len, 96);
    chk("def_fs_none", fs_n, 0);
    chk("def_max_x", max_x, 639);
    cyc(1, 0);
    cyc(1, 1);
    chk("sm_fc_rst", s_fc, 0);
    for (int i = 1; i <= 192; i++) begin
      cyc(0, 1);
      if (i == 1) chk("sm_fs_first", s_fs, 1);
      if (i % 48 == 0) chk("sm_fc_seq", s_fc, (i / 48) % 4);
    end
    cyc(1, 1);
    ls_n = 0; dbl = 0; prev = 0;
    for (int i = 0; i < 96; i++) begin
      cyc(0, i % 2 == 0);
      if (s_ls) ls_n++;
      if (s_ls && prev) dbl++;
      prev = s_ls;
    end
    chk("tog_ls_cnt", ls_n, 6);
    chk("tog_ls_width", dbl, 0);
    chk("tog_fc", s_fc, 1);
    for (int i = 0; i < 48 && !(mh == 5 && mv == 2); i++) cyc(0, 1);
    chk("mid_pos", mh * 16 + mv, 5 * 16 + 2);
    cyc(1, 1);
    chk("mid_rst_fc", s_fc, 0);
    chk("mid_rst_hs", s_hs, 1);
    chk("mid_rst_phs", p_hs, 0);
    cyc(0, 1);
    chk("mid_fs", s_fs, 1);
    chk("mid_x", s_x, 0);
    for (int i = 0; i < 120; i++) cyc(0, 1'($urandom_range(0, 1)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
